// File: rtl/pipe_mem_pkg.sv
// Shared types for the unified memory-port arbiter: FSM states, bus owner, fetch byte-enable.
package pipe_mem_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DATA, DONE} state_e;
  typedef enum logic {OWN_IF, OWN_MEM} owner_e;
  localparam logic [3:0] BE_FULL = 4'b1111;
endpackage

// File: rtl/pipe_mem_port_arbiter.sv
// Arbitrates one memory bus between instruction fetch and data load/store.
// Data wins ties; fetch is forced through after STARVE_LIMIT consecutive data grants.
module pipe_mem_port_arbiter
  import pipe_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_byteenable,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic [31:0] bus_address,
  output logic [31:0] bus_writedata,
  output logic [3:0]  bus_byteenable,
  output logic        bus_read,
  output logic        bus_write,
  input  logic [31:0] bus_readdata,
  input  logic        bus_waitrequest,
  output logic        fetch_mem_sel
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] SMAX  = {SW{1'b1}};

  state_e      state_q;
  owner_e      owner_q;
  logic [SW-1:0] streak_q, streak_d;
  logic [31:0] if_rdata_q, mem_rdata_q, addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        rd_q, wr_q, if_ack_q, mem_ack_q, sel_q;
  logic        grant_fetch, grant_data;

  always_comb begin
    grant_fetch = if_req && (!mem_req || streak_q == LIMIT);
    grant_data  = mem_req && !grant_fetch;
    streak_d    = '0;
    if (if_req) streak_d = (streak_q == SMAX) ? streak_q : streak_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      streak_q    <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      sel_q       <= 1'b1;
    end else begin
      if_ack_q  <= 1'b0;
      mem_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_fetch) begin
            state_q  <= FETCH;
            owner_q  <= OWN_IF;
            rd_q     <= 1'b1;
            wr_q     <= 1'b0;
            addr_q   <= if_addr;
            wdata_q  <= '0;
            be_q     <= BE_FULL;
            streak_q <= '0;
            sel_q    <= 1'b1;
          end else if (grant_data) begin
            state_q  <= DATA;
            owner_q  <= OWN_MEM;
            rd_q     <= !mem_we;
            wr_q     <= mem_we;
            addr_q   <= mem_addr;
            wdata_q  <= mem_wdata;
            be_q     <= mem_byteenable;
            streak_q <= streak_d;
            sel_q    <= 1'b0;
          end
        end
        FETCH, DATA: begin
          // Command registers stay untouched while the bus stalls.
          if (!bus_waitrequest) begin
            state_q <= DONE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            if (owner_q == OWN_IF) begin
              if_rdata_q <= bus_readdata;
              if_ack_q   <= 1'b1;
            end else begin
              if (!wr_q) mem_rdata_q <= bus_readdata;
              mem_ack_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          sel_q   <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_rdata       = if_rdata_q;
  assign if_ack         = if_ack_q;
  assign mem_rdata      = mem_rdata_q;
  assign mem_ack        = mem_ack_q;
  assign bus_address    = addr_q;
  assign bus_writedata  = wdata_q;
  assign bus_byteenable = be_q;
  assign bus_read       = rd_q;
  assign bus_write      = wr_q;
  assign fetch_mem_sel  = sel_q;
endmodule
